// File: rtl/bus_arbiter_if.sv
// Bus bundle between three masters, the arbiter and the rom/ram slaves.
// master: the arbiter's own view; slave: the surrounding masters and slave devices.
interface bus_arbiter_if;
    logic        m0_req_i, m1_req_i, m2_req_i;
    logic        m0_we_i, m1_we_i, m2_we_i;
    logic [31:0] m0_addr_i, m1_addr_i, m2_addr_i;
    logic [31:0] m0_data_i, m1_data_i, m2_data_i;
    logic [31:0] m0_data_o, m1_data_o, m2_data_o;
    logic        m0_ack_o, m1_ack_o, m2_ack_o;
    logic        m0_err_o, m1_err_o, m2_err_o;
    logic        m0_stall_o, m1_stall_o, m2_stall_o;

    logic        s0_req_o, s1_req_o;
    logic        s0_we_o, s1_we_o;
    logic [31:0] s0_addr_o, s1_addr_o;
    logic [31:0] s0_data_o, s1_data_o;
    logic [31:0] s0_data_i, s1_data_i;
    logic        s0_ack_i, s1_ack_i;

    modport master (
        input  m0_req_i, m1_req_i, m2_req_i, m0_we_i, m1_we_i, m2_we_i,
        input  m0_addr_i, m1_addr_i, m2_addr_i, m0_data_i, m1_data_i, m2_data_i,
        output m0_data_o, m1_data_o, m2_data_o, m0_ack_o, m1_ack_o, m2_ack_o,
        output m0_err_o, m1_err_o, m2_err_o, m0_stall_o, m1_stall_o, m2_stall_o,
        output s0_req_o, s1_req_o, s0_we_o, s1_we_o,
        output s0_addr_o, s1_addr_o, s0_data_o, s1_data_o,
        input  s0_data_i, s1_data_i, s0_ack_i, s1_ack_i
    );

    modport slave (
        output m0_req_i, m1_req_i, m2_req_i, m0_we_i, m1_we_i, m2_we_i,
        output m0_addr_i, m1_addr_i, m2_addr_i, m0_data_i, m1_data_i, m2_data_i,
        input  m0_data_o, m1_data_o, m2_data_o, m0_ack_o, m1_ack_o, m2_ack_o,
        input  m0_err_o, m1_err_o, m2_err_o, m0_stall_o, m1_stall_o, m2_stall_o,
        input  s0_req_o, s1_req_o, s0_we_o, s1_we_o,
        input  s0_addr_o, s1_addr_o, s0_data_o, s1_data_o,
        output s0_data_i, s1_data_i, s0_ack_i, s1_ack_i
    );
endinterface

// File: rtl/bus_arbiter.sv
// Three-master, two-slave bus arbiter: fixed priority m2 > m0 > m1 with an m1
// starvation guard, address decode on addr[31:28] and a slave-ack timeout.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int FAIR_LIMIT     = 4
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FAIR_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    req, win, grant, ack;
    logic          win_we, we_r, err_r;
    logic [31:0]   win_addr, win_wdata, addr_r, wdata_r, rdata_r;
    logic [FW-1:0] fair_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          busy, sel0, sel1, unmapped, ack_sel, timeout;

    assign req      = {bus.m2_req_i, bus.m1_req_i, bus.m0_req_i};
    assign busy     = (state == BUSY);
    assign sel0     = (addr_r[31:28] == 4'h0);
    assign sel1     = (addr_r[31:28] == 4'h1);
    assign unmapped = !sel0 && !sel1;
    // Slave acks only count while that slave is being strobed.
    assign ack_sel  = busy && ((sel0 && bus.s0_ack_i) || (sel1 && bus.s1_ack_i));
    assign timeout  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // m1 jumps ahead of m0 once m0 has been granted FAIR_LIMIT times in a row.
    always_comb begin
        win       = 3'b000;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (req[2]) begin
            win = 3'b100; win_we = bus.m2_we_i; win_addr = bus.m2_addr_i; win_wdata = bus.m2_data_i;
        end else if (req[1] && (!req[0] || fair_cnt == FW'(FAIR_LIMIT))) begin
            win = 3'b010; win_we = bus.m1_we_i; win_addr = bus.m1_addr_i; win_wdata = bus.m1_data_i;
        end else if (req[0]) begin
            win = 3'b001; win_we = bus.m0_we_i; win_addr = bus.m0_addr_i; win_wdata = bus.m0_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.s0_req_o  = 1'b0;
        bus.s0_we_o   = 1'b0;
        bus.s0_addr_o = '0;
        bus.s0_data_o = '0;
        bus.s1_req_o  = 1'b0;
        bus.s1_we_o   = 1'b0;
        bus.s1_addr_o = '0;
        bus.s1_data_o = '0;
        unique case (state)
            IDLE: if (|req) state_nxt = BUSY;
            BUSY: begin
                if (sel0) begin
                    bus.s0_req_o  = 1'b1;
                    bus.s0_we_o   = we_r;
                    bus.s0_addr_o = addr_r;
                    bus.s0_data_o = wdata_r;
                end
                if (sel1) begin
                    bus.s1_req_o  = 1'b1;
                    bus.s1_we_o   = we_r;
                    bus.s1_addr_o = addr_r;
                    bus.s1_data_o = wdata_r;
                end
                if (unmapped || ack_sel || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
            fair_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: if (|req) begin
                    grant   <= win;
                    we_r    <= win_we;
                    addr_r  <= win_addr;
                    wdata_r <= win_wdata;
                    tmo_cnt <= '0;
                    if (win[1])
                        fair_cnt <= '0;
                    else if (win[0])
                        fair_cnt <= !req[1] ? '0 :
                                    (fair_cnt == FW'(FAIR_LIMIT)) ? fair_cnt : fair_cnt + 1'b1;
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (ack_sel) begin
                        rdata_r <= we_r ? 32'h0 : (sel1 ? bus.s1_data_i : bus.s0_data_i);
                        err_r   <= 1'b0;
                    end else if (unmapped || timeout) begin
                        rdata_r <= '0;
                        err_r   <= 1'b1;
                    end
                end
                DONE:    grant <= '0;
                default: grant <= '0;
            endcase
        end
    end

    assign ack = (state == DONE) ? grant : 3'b000;

    assign bus.m0_ack_o   = ack[0];
    assign bus.m1_ack_o   = ack[1];
    assign bus.m2_ack_o   = ack[2];
    assign bus.m0_err_o   = ack[0] & err_r;
    assign bus.m1_err_o   = ack[1] & err_r;
    assign bus.m2_err_o   = ack[2] & err_r;
    assign bus.m0_data_o  = ack[0] ? rdata_r : 32'h0;
    assign bus.m1_data_o  = ack[1] ? rdata_r : 32'h0;
    assign bus.m2_data_o  = ack[2] ? rdata_r : 32'h0;
    assign bus.m0_stall_o = bus.m0_req_i & ~ack[0];
    assign bus.m1_stall_o = bus.m1_req_i & ~ack[1];
    assign bus.m2_stall_o = bus.m2_req_i & ~ack[2];
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed transactions push expected
// completions, a negedge monitor pops and compares on every master ack.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT_CYCLES(16), .FAIR_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] S0_RD = 32'h1234_5678;
    localparam logic [31:0] S1_RD = 32'hCAFE_0001;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic s0_ack_en = 1'b1, s1_ack_en = 1'b1, s0_ack_stray = 1'b0;

    assign bus.s0_ack_i  = s0_ack_stray | (bus.s0_req_o & s0_ack_en);
    assign bus.s1_ack_i  = bus.s1_req_o & s1_ack_en;
    assign bus.s0_data_i = S0_RD;
    assign bus.s1_data_i = S1_RD;

    int          s0_cyc, s1_cyc;
    logic        snap_we, snap_stall;
    logic [31:0] snap_addr, snap_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] d, input logic e);
        exp_t x;
        x.m = m; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    function automatic logic [2:0] acks();
        return {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
    endfunction

    function automatic logic [31:0] data_of(input int m);
        return (m == 2) ? bus.m2_data_o : (m == 1) ? bus.m1_data_o : bus.m0_data_o;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 2) ? bus.m2_err_o : (m == 1) ? bus.m1_err_o : bus.m0_err_o;
    endfunction

    function automatic logic stall_of(input int m);
        return (m == 2) ? bus.m2_stall_o : (m == 1) ? bus.m1_stall_o : bus.m0_stall_o;
    endfunction

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        case (m)
            0: begin bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_data_i = data; end
            1: begin bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_data_i = data; end
            default: begin bus.m2_req_i = req; bus.m2_we_i = we; bus.m2_addr_i = addr; bus.m2_data_i = data; end
        endcase
    endtask

    // Monitor: every master ack is matched against the head of the scoreboard.
    always @(negedge clk) begin
        logic [2:0] a;
        int         m;
        exp_t       e;
        a = acks();
        if (!rst && a != 3'b000) begin
            check("single_ack", 32'($countones(a)), 32'd1);
            m = a[2] ? 2 : (a[1] ? 1 : 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: master %0d acked, nothing expected", m);
            end else begin
                e = sb.pop_front();
                check("ack_master", 32'(m), 32'(e.m));
                check("ack_data", data_of(m), e.data);
                check("ack_err", 32'(err_of(m)), 32'(e.err));
                for (int i = 0; i < 3; i++)
                    if (i != m) check("idle_master_outputs", data_of(i) | 32'(err_of(i)), 32'h0);
            end
        end
    end

    task automatic single(input string name, input int m, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int n;
        push_exp(m, exp_data, exp_err);
        drive(m, 1'b1, we, addr, wdata);
        n = 0; s0_cyc = 0; s1_cyc = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.s0_req_o) s0_cyc++;
            if (bus.s1_req_o) s1_cyc++;
            if (n == 1) begin
                snap_we = bus.s1_we_o; snap_addr = bus.s1_addr_o;
                snap_data = bus.s1_data_o; snap_stall = stall_of(m);
            end
        end while (!acks()[m] && n < 60);
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_stall_at_ack"}, 32'(stall_of(m)), 32'h0);
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, cnt;
        logic [2:0] seen;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state, including a request that must not be granted during reset.
        drive(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_s_req", {30'h0, bus.s1_req_o, bus.s0_req_o}, 32'h0);
        check("rst_s_addr", bus.s0_addr_o | bus.s1_addr_o, 32'h0);
        check("rst_s_data", bus.s0_data_o | bus.s1_data_o | 32'(bus.s0_we_o) | 32'(bus.s1_we_o), 32'h0);
        check("rst_acks", 32'(acks()), 32'h0);
        check("rst_m_data", bus.m0_data_o | bus.m1_data_o | bus.m2_data_o, 32'h0);
        check("rst_m_err", {29'h0, bus.m2_err_o, bus.m1_err_o, bus.m0_err_o}, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // m1 read from rom, slave acks in its first BUSY cycle.
        single("m1_read", 1, 1'b0, 32'h0000_0010, 32'h0, S0_RD, 1'b0, 2);
        check("m1_read_s0_cycles", 32'(s0_cyc), 32'd1);
        check("m1_read_stall_busy", 32'(snap_stall), 32'd1);

        // m0 write to ram.
        single("m0_write", 0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        check("wr_s1_we", 32'(snap_we), 32'd1);
        check("wr_s1_addr", snap_addr, 32'h1000_0004);
        check("wr_s1_data", snap_data, 32'hDEAD_BEEF);
        check("wr_s0_req_cycles", 32'(s0_cyc), 32'd0);
        check("wr_s1_req_cycles", 32'(s1_cyc), 32'd1);

        // Unmapped address.
        single("unmapped", 0, 1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1, 2);
        check("unmapped_req_cycles", 32'(s0_cyc + s1_cyc), 32'd0);

        // Ram never acks; a stray rom ack must be ignored.
        s1_ack_en = 1'b0; s0_ack_stray = 1'b1;
        single("timeout", 0, 1'b0, 32'h1000_0008, 32'h0, 32'h0, 1'b1, 17);
        check("timeout_s1_cycles", 32'(s1_cyc), 32'd16);
        check("timeout_s0_cycles", 32'(s0_cyc), 32'd0);
        s0_ack_stray = 1'b0;

        // Reset in the middle of a stalled transaction.
        drive(0, 1'b1, 1'b0, 32'h1000_0008, 32'h0);
        repeat (4) @(negedge clk);
        check("busy_s1_req", 32'(bus.s1_req_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_s1_req", 32'(bus.s1_req_o), 32'd0);
        check("async_rst_s1_addr", bus.s1_addr_o, 32'h0);
        check("async_rst_acks", 32'(acks()), 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        s1_ack_en = 1'b1;
        seen = 3'b000;
        repeat (2) begin @(negedge clk); seen |= acks(); end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); seen |= acks(); end
        check("no_ack_after_abandon", 32'(seen), 32'h0);

        // Arbitration resumes right after reset release.
        single("post_rst", 2, 1'b0, 32'h1000_0000, 32'h0, S1_RD, 1'b0, 2);

        // Fairness: m0 and m1 both request continuously.
        for (int i = 0; i < 10; i++)
            if (i % 5 == 4) push_exp(1, S1_RD, 1'b0);
            else            push_exp(0, S0_RD, 1'b0);
        drive(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
        n = 0; cnt = 0;
        while (cnt < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (acks() != 3'b000) cnt++;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("fair_ack_count", 32'(cnt), 32'd10);

        // Simultaneous requests: m2, then m0, then m1.
        push_exp(2, S1_RD, 1'b0);
        push_exp(0, 32'h0, 1'b0);
        push_exp(1, S0_RD, 1'b0);
        drive(2, 1'b1, 1'b0, 32'h1000_0030, 32'h0);
        drive(0, 1'b1, 1'b1, 32'h1000_0040, 32'h5555_AAAA);
        drive(1, 1'b1, 1'b0, 32'h0000_0050, 32'h0);
        n = 0; cnt = 0;
        while (cnt < 3 && n < 100) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 3; i++)
                if (acks()[i]) begin
                    cnt++;
                    drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
                end
        end
        @(negedge clk);
        check("prio_ack_count", 32'(cnt), 32'd3);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
